kamus_lsu: RTL and testbench
============================

// Module: kamus_lsu
// PURPOSE
//  Load/store unit; the memory-side consumer of the ID-EX decoded record. Takes one
//  load/store op (LB..SB of operation_e) with computed address and store data from EX.
//  Runs a req/gnt/rvalid transaction on the data bus and aligns/extends load data.
//  Returns it to writeback tagged MEM_RESULT (wb_options_e).
// PARAMETERS
//  BUS_TIMEOUT  255  cycles allowed in REQ+RESP before bus_err_o; 0 = timeout disabled
// PORTS
//  clk_i          in   1   clock; all logic on rising edge
//  rst_i          in   1   reset: synchronous, active-high
//  lsu_valid_i    in   1   EX presents an op
//  lsu_ready_o    out  1   LSU accepts op this cycle (state==IDLE && !rst_i)
//  lsu_op_i       in   6   operation_e (LB,LH,LW,LBU,LHU,SB,SH,SW)
//  lsu_addr_i     in   32  byte address (rs1+imm)
//  lsu_wdata_i    in   32  store data (rs2)
//  lsu_rd_i       in   5   load destination register
//  data_req_o     out  1   bus request
//  data_gnt_i     in   1   bus grant
//  data_addr_o    out  32  word-aligned address {addr[31:2],2'b00}
//  data_we_o      out  1   1=store
//  data_be_o      out  4   byte enables
//  data_wdata_o   out  32  lane-replicated store data
//  data_rvalid_i  in   1   read data valid
//  data_rdata_i   in   32  read data word
//  wb_valid_o     out  1   one-cycle load result pulse
//  wb_rd_o        out  5   destination register
//  wb_data_o      out  32  extended load data
//  wb_sel_o       out  2   constant MEM_RESULT (2'b01)
//  misaligned_o   out  1   one-cycle pulse: misaligned access dropped
//  bus_err_o      out  1   one-cycle pulse: timeout, op abandoned
// BEHAVIOUR
//  Reset: state IDLE, timeout counter 0. All outputs 0 except wb_sel_o=2'b01.
//  lsu_ready_o is 0 while rst_i=1 and 1 after reset.
//  FSM IDLE->REQ->(RESP)->IDLE. Accept on lsu_valid_i&&lsu_ready_o; latch op/addr/wdata/rd.
//  Misaligned (H with addr[0]!=0, W with addr[1:0]!=0): no bus access; misaligned_o=1 the
//   next cycle; state stays IDLE.
//  Non-load/store op accepted: dropped silently, no outputs.
//  REQ: data_req_o=1 and all data_* stable until data_gnt_i=1.
//   On grant: store->IDLE (no wb); load->RESP; data_req_o=0 next cycle.
//  Store lanes (o=addr[1:0]): SB be=4'b0001<<o, wdata={4{b}}; SH be=4'b0011<<o,
//   wdata={2{h}}; SW be=4'b1111. Loads drive be=4'b1111, we=0.
//  RESP: on data_rvalid_i select byte/half at offset o:
//   LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
//   Register the result; wb_valid_o=1 for exactly one cycle next edge; go IDLE.
//   wb_valid_o is suppressed when rd==0; the access is still performed.
//  Min latency: accept c0, req c1, gnt c1, rvalid c2, wb_valid_o c3. Store: done after gnt.
//   Next accept in the cycle after return to IDLE.
//  data_rvalid_i is ignored in IDLE and REQ (stale/late responses dropped).
//  Timeout: counter clears on accept and increments each cycle in REQ/RESP.
//   At ==BUS_TIMEOUT: bus_err_o pulses, data_req_o drops, state->IDLE, no wb.
//  Reset mid-op: IDLE next edge, data_req_o=0, no wb/err pulse; later rvalid ignored.
// TESTING
//  LW addr 0x100, gnt same cycle, rvalid c2 rdata 0xDEADBEEF, rd=5 -> wb_valid c3,
//   wb_data 0xDEADBEEF, wb_rd 5
//  LB addr 0x103 rdata 0x80FF_FFFF -> wb_data 0xFFFFFF80; LBU same -> 0x00000080;
//   LHU addr 0x102 -> 0x000080FF
//  SH addr 0x102 wdata 0x1234ABCD, gnt held low 3 cycles -> req/addr 0x100/be 4'b1100/
//   wdata 0xABCDABCD stable 4 cycles; no wb
//  LW addr 0x101 -> misaligned_o one pulse, data_req_o never asserted, ready next cycle
//  BUS_TIMEOUT=4, LW, rvalid never -> bus_err_o pulse 4 cycles after accept; then late
//   rvalid -> no wb
//  rst_i asserted while in RESP -> req low, IDLE next edge; load to rd=0 -> bus access, no wb

Source files
------------

// File: rtl/kamus_lsu.sv
// kamus_lsu: load/store unit. Accepts one load/store op from EX, runs a req/gnt/rvalid
// transaction on the data bus, and returns aligned, extended load data to writeback.
module kamus_lsu #(
  parameter int unsigned BUS_TIMEOUT = 255  // cycles allowed in REQ+RESP; 0 disables
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // EX side
  input  logic        lsu_valid_i,
  output logic        lsu_ready_o,
  input  logic [5:0]  lsu_op_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [4:0]  lsu_rd_i,
  // data bus
  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  // writeback
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic [1:0]  wb_sel_o,
  // status
  output logic        misaligned_o,
  output logic        bus_err_o
);

  // operation_e encodings for the memory ops
  localparam logic [5:0] OP_LB  = 6'd10;
  localparam logic [5:0] OP_LH  = 6'd11;
  localparam logic [5:0] OP_LW  = 6'd12;
  localparam logic [5:0] OP_LBU = 6'd13;
  localparam logic [5:0] OP_LHU = 6'd14;
  localparam logic [5:0] OP_SB  = 6'd15;
  localparam logic [5:0] OP_SH  = 6'd16;
  localparam logic [5:0] OP_SW  = 6'd17;

  localparam logic [1:0] MEM_RESULT = 2'b01;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e      state_q, state_d;

  logic [31:0] addr_q;
  logic [1:0]  off_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [5:0]  op_q;
  logic [4:0]  rd_q;
  logic [31:0] cnt_q;

  logic        wb_valid_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;
  logic        mis_q;
  logic        err_q;

  logic        accept;
  logic        is_load;
  logic        is_store;
  logic [1:0]  size;
  logic        misaligned;
  logic        start_bus;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;

  logic        timeout_hit;
  logic        load_done;
  logic        err_set;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_data;

  assign lsu_ready_o = (state_q == StIdle) && !rst_i;
  assign accept      = lsu_valid_i && lsu_ready_o;

  // Decode the incoming op: class, access size, alignment and store lane placement
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    size      = SZ_WORD;
    be_new    = 4'b1111;
    wdata_new = '0;
    case (lsu_op_i)
      OP_LB, OP_LBU: begin
        is_load = 1'b1;
        size    = SZ_BYTE;
      end
      OP_LH, OP_LHU: begin
        is_load = 1'b1;
        size    = SZ_HALF;
      end
      OP_LW: begin
        is_load = 1'b1;
        size    = SZ_WORD;
      end
      OP_SB: begin
        is_store  = 1'b1;
        size      = SZ_BYTE;
        be_new    = 4'b0001 << lsu_addr_i[1:0];
        wdata_new = {4{lsu_wdata_i[7:0]}};
      end
      OP_SH: begin
        is_store  = 1'b1;
        size      = SZ_HALF;
        be_new    = 4'b0011 << lsu_addr_i[1:0];
        wdata_new = {2{lsu_wdata_i[15:0]}};
      end
      OP_SW: begin
        is_store  = 1'b1;
        size      = SZ_WORD;
        wdata_new = lsu_wdata_i;
      end
      default: begin
        is_load  = 1'b0;
        is_store = 1'b0;
      end
    endcase
    misaligned = ((size == SZ_HALF) && lsu_addr_i[0]) ||
                 ((size == SZ_WORD) && (lsu_addr_i[1:0] != 2'b00));
    start_bus  = accept && (is_load || is_store) && !misaligned;
  end

  // Pick the addressed byte/half from the returned word and extend per op
  always_comb begin
    byte_sel = data_rdata_i[7:0];
    case (off_q)
      2'd0: byte_sel = data_rdata_i[7:0];
      2'd1: byte_sel = data_rdata_i[15:8];
      2'd2: byte_sel = data_rdata_i[23:16];
      2'd3: byte_sel = data_rdata_i[31:24];
      default: byte_sel = data_rdata_i[7:0];
    endcase
    half_sel = off_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
    ld_data  = data_rdata_i;
    case (op_q)
      OP_LB:   ld_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  ld_data = {24'h0, byte_sel};
      OP_LH:   ld_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  ld_data = {16'h0, half_sel};
      default: ld_data = data_rdata_i;
    endcase
  end

  assign timeout_hit = (BUS_TIMEOUT != 0) && ((cnt_q + 32'd1) == BUS_TIMEOUT);

  // Next-state logic; a grant or response arriving in the last allowed cycle wins over timeout
  always_comb begin
    state_d   = state_q;
    load_done = 1'b0;
    err_set   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_bus) state_d = StReq;
      end
      StReq: begin
        if (data_gnt_i) begin
          state_d = we_q ? StIdle : StResp;
        end else if (timeout_hit) begin
          state_d = StIdle;
          err_set = 1'b1;
        end
      end
      StResp: begin
        if (data_rvalid_i) begin
          state_d   = StIdle;
          load_done = 1'b1;
        end else if (timeout_hit) begin
          state_d = StIdle;
          err_set = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Latched op, timeout counter and registered result/status pulses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q     <= '0;
      off_q      <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      op_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      mis_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      mis_q      <= accept && (is_load || is_store) && misaligned;
      err_q      <= err_set;
      wb_valid_q <= load_done && (rd_q != 5'd0);
      if (load_done) begin
        wb_rd_q   <= rd_q;
        wb_data_q <= ld_data;
      end
      if (accept) begin
        addr_q  <= {lsu_addr_i[31:2], 2'b00};
        off_q   <= lsu_addr_i[1:0];
        be_q    <= be_new;
        wdata_q <= wdata_new;
        we_q    <= is_store;
        op_q    <= lsu_op_i;
        rd_q    <= lsu_rd_i;
        cnt_q   <= '0;
      end else if (state_q != StIdle) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  // Bus signals are only driven while a request is outstanding
  always_comb begin
    data_req_o   = (state_q == StReq) && !rst_i;
    data_addr_o  = data_req_o ? addr_q : '0;
    data_we_o    = data_req_o ? we_q : 1'b0;
    data_be_o    = data_req_o ? be_q : '0;
    data_wdata_o = data_req_o ? wdata_q : '0;
  end

  assign wb_valid_o   = wb_valid_q;
  assign wb_rd_o      = wb_rd_q;
  assign wb_data_o    = wb_data_q;
  assign wb_sel_o     = MEM_RESULT;
  assign misaligned_o = mis_q;
  assign bus_err_o    = err_q;

endmodule

// File: tb/tb_kamus_lsu.sv
// tb_kamus_lsu: directed, table-driven bench for kamus_lsu (BUS_TIMEOUT = 4).
module tb_kamus_lsu;

  localparam logic [5:0] LB  = 6'd10;
  localparam logic [5:0] LH  = 6'd11;
  localparam logic [5:0] LW  = 6'd12;
  localparam logic [5:0] LBU = 6'd13;
  localparam logic [5:0] LHU = 6'd14;
  localparam logic [5:0] SB  = 6'd15;
  localparam logic [5:0] SH  = 6'd16;
  localparam logic [5:0] SW  = 6'd17;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [5:0]  lsu_op;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [4:0]  lsu_rd;
  logic        data_req;
  logic        data_gnt;
  logic [31:0] data_addr;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [1:0]  wb_sel;
  logic        misaligned;
  logic        bus_err;

  int n_cmp = 0;
  int n_bad = 0;

  kamus_lsu #(.BUS_TIMEOUT(4)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .lsu_valid_i   (lsu_valid),
    .lsu_ready_o   (lsu_ready),
    .lsu_op_i      (lsu_op),
    .lsu_addr_i    (lsu_addr),
    .lsu_wdata_i   (lsu_wdata),
    .lsu_rd_i      (lsu_rd),
    .data_req_o    (data_req),
    .data_gnt_i    (data_gnt),
    .data_addr_o   (data_addr),
    .data_we_o     (data_we),
    .data_be_o     (data_be),
    .data_wdata_o  (data_wdata),
    .data_rvalid_i (data_rvalid),
    .data_rdata_i  (data_rdata),
    .wb_valid_o    (wb_valid),
    .wb_rd_o       (wb_rd),
    .wb_data_o     (wb_data),
    .wb_sel_o      (wb_sel),
    .misaligned_o  (misaligned),
    .bus_err_o     (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_wb;
    logic [31:0] exp_data;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd);
    lsu_valid = 1'b1;
    lsu_op    = op;
    lsu_addr  = addr;
    lsu_wdata = wdata;
    lsu_rd    = rd;
  endtask

  // Minimum-latency transaction: accept c0, gnt c1, rvalid c2, wb c3
  task automatic run_vec(input vec_t v, input int idx);
    present(v.op, v.addr, v.wdata, v.rd);
    @(negedge clk);
    chk($sformatf("v%0d.ready", idx), {31'b0, lsu_ready}, 32'd1);
    step();
    lsu_valid = 1'b0;
    data_gnt  = 1'b1;
    @(negedge clk);
    chk($sformatf("v%0d.req", idx), {31'b0, data_req}, 32'd1);
    chk($sformatf("v%0d.addr", idx), data_addr, v.addr & 32'hFFFF_FFFC);
    chk($sformatf("v%0d.be", idx), {28'b0, data_be}, {28'b0, v.exp_be});
    chk($sformatf("v%0d.we", idx), {31'b0, data_we}, {31'b0, v.we});
    if (v.we) chk($sformatf("v%0d.wdata", idx), data_wdata, v.exp_wdata);
    step();
    data_gnt = 1'b0;
    if (!v.we) begin
      data_rvalid = 1'b1;
      data_rdata  = v.rdata;
      @(negedge clk);
      chk($sformatf("v%0d.req_resp", idx), {31'b0, data_req}, 32'd0);
      step();
      data_rvalid = 1'b0;
      data_rdata  = 32'h0;
    end
    @(negedge clk);
    chk($sformatf("v%0d.wb_valid", idx), {31'b0, wb_valid}, {31'b0, v.exp_wb});
    if (v.exp_wb) begin
      chk($sformatf("v%0d.wb_data", idx), wb_data, v.exp_data);
      chk($sformatf("v%0d.wb_rd", idx), {27'b0, wb_rd}, {27'b0, v.rd});
    end
    chk($sformatf("v%0d.wb_sel", idx), {30'b0, wb_sel}, 32'd1);
    chk($sformatf("v%0d.ready_after", idx), {31'b0, lsu_ready}, 32'd1);
    step();
    @(negedge clk);
    chk($sformatf("v%0d.wb_one_pulse", idx), {31'b0, wb_valid}, 32'd0);
    step();
  endtask

  task automatic run_misaligned(input logic [5:0] op, input logic [31:0] addr, input string nm);
    present(op, addr, 32'hFFFF_FFFF, 5'd3);
    step();
    lsu_valid = 1'b0;
    @(negedge clk);
    chk({nm, ".mis_pulse"}, {31'b0, misaligned}, 32'd1);
    chk({nm, ".no_req"}, {31'b0, data_req}, 32'd0);
    chk({nm, ".ready"}, {31'b0, lsu_ready}, 32'd1);
    step();
    @(negedge clk);
    chk({nm, ".mis_clear"}, {31'b0, misaligned}, 32'd0);
    chk({nm, ".no_req2"}, {31'b0, data_req}, 32'd0);
    step();
  endtask

  vec_t vecs[12];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{LW,  32'h100, 32'h0,         5'd5, 32'hDEADBEEF, 1'b0, 4'hF, 32'h0,         1'b1, 32'hDEADBEEF};
    vecs[1]  = '{LB,  32'h103, 32'h0,         5'd6, 32'h80FFFFFF, 1'b0, 4'hF, 32'h0,         1'b1, 32'hFFFFFF80};
    vecs[2]  = '{LBU, 32'h103, 32'h0,         5'd7, 32'h80FFFFFF, 1'b0, 4'hF, 32'h0,         1'b1, 32'h00000080};
    vecs[3]  = '{LHU, 32'h102, 32'h0,         5'd8, 32'h80FFFFFF, 1'b0, 4'hF, 32'h0,         1'b1, 32'h000080FF};
    vecs[4]  = '{LH,  32'h102, 32'h0,         5'd9, 32'h80FFFFFF, 1'b0, 4'hF, 32'h0,         1'b1, 32'hFFFF80FF};
    vecs[5]  = '{LB,  32'h101, 32'h0,         5'd10, 32'h12347F56, 1'b0, 4'hF, 32'h0,        1'b1, 32'h0000007F};
    vecs[6]  = '{LH,  32'h100, 32'h0,         5'd11, 32'h00008001, 1'b0, 4'hF, 32'h0,        1'b1, 32'hFFFF8001};
    vecs[7]  = '{LBU, 32'h100, 32'h0,         5'd31, 32'h000000FE, 1'b0, 4'hF, 32'h0,        1'b1, 32'h000000FE};
    vecs[8]  = '{SB,  32'h102, 32'h000000A5,  5'd0, 32'h0,        1'b1, 4'b0100, 32'hA5A5A5A5, 1'b0, 32'h0};
    vecs[9]  = '{SW,  32'h200, 32'hCAFEF00D,  5'd0, 32'h0,        1'b1, 4'b1111, 32'hCAFEF00D, 1'b0, 32'h0};
    vecs[10] = '{SH,  32'h100, 32'h1234ABCD,  5'd0, 32'h0,        1'b1, 4'b0011, 32'hABCDABCD, 1'b0, 32'h0};
    vecs[11] = '{LW,  32'h104, 32'h0,         5'd0, 32'h55AA55AA, 1'b0, 4'hF, 32'h0,         1'b0, 32'h0};

    rst = 1'b1; lsu_valid = 1'b0; lsu_op = '0; lsu_addr = '0; lsu_wdata = '0; lsu_rd = '0;
    data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = '0;

    // Reset state
    step();
    @(negedge clk);
    chk("rst.ready_low", {31'b0, lsu_ready}, 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst.ready", {31'b0, lsu_ready}, 32'd1);
    chk("rst.req", {31'b0, data_req}, 32'd0);
    chk("rst.wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst.wb_sel", {30'b0, wb_sel}, 32'd1);
    chk("rst.mis", {31'b0, misaligned}, 32'd0);
    chk("rst.err", {31'b0, bus_err}, 32'd0);
    chk("rst.wb_data", wb_data, 32'd0);
    step();

    // Table-driven minimum-latency loads and stores
    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // SH with grant held low 3 cycles: bus fields stable for 4 cycles, grant in last allowed cycle
    present(SH, 32'h102, 32'h1234ABCD, 5'd4);
    step();
    lsu_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      data_gnt = (k == 3);
      @(negedge clk);
      chk($sformatf("sh_wait%0d.req", k), {31'b0, data_req}, 32'd1);
      chk($sformatf("sh_wait%0d.addr", k), data_addr, 32'h100);
      chk($sformatf("sh_wait%0d.be", k), {28'b0, data_be}, 32'hC);
      chk($sformatf("sh_wait%0d.wdata", k), data_wdata, 32'hABCDABCD);
      chk($sformatf("sh_wait%0d.we", k), {31'b0, data_we}, 32'd1);
      step();
    end
    data_gnt = 1'b0;
    @(negedge clk);
    chk("sh_wait.req_done", {31'b0, data_req}, 32'd0);
    chk("sh_wait.no_wb", {31'b0, wb_valid}, 32'd0);
    chk("sh_wait.no_err", {31'b0, bus_err}, 32'd0);
    chk("sh_wait.ready", {31'b0, lsu_ready}, 32'd1);
    step();

    // Misaligned accesses
    run_misaligned(LW, 32'h101, "mis_lw");
    run_misaligned(SH, 32'h103, "mis_sh");

    // Non-memory op is dropped silently
    present(6'd3, 32'h100, 32'h0, 5'd1);
    step();
    lsu_valid = 1'b0;
    @(negedge clk);
    chk("nop.req", {31'b0, data_req}, 32'd0);
    chk("nop.mis", {31'b0, misaligned}, 32'd0);
    chk("nop.ready", {31'b0, lsu_ready}, 32'd1);
    step();

    // Timeout with no grant: 4 cycles in REQ, error pulse the cycle after
    present(LW, 32'h300, 32'h0, 5'd7);
    step();
    lsu_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("to_req.c%0d.req", k), {31'b0, data_req}, (k <= 4) ? 32'd1 : 32'd0);
      chk($sformatf("to_req.c%0d.err", k), {31'b0, bus_err}, (k == 5) ? 32'd1 : 32'd0);
      step();
    end

    // Timeout waiting for rvalid, then a late response must be ignored
    present(LW, 32'h300, 32'h0, 5'd7);
    step();
    lsu_valid = 1'b0;
    data_gnt  = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      data_rvalid = (k == 6);
      data_rdata  = (k == 6) ? 32'h12345678 : 32'h0;
      @(negedge clk);
      chk($sformatf("to_resp.c%0d.err", k), {31'b0, bus_err}, (k == 5) ? 32'd1 : 32'd0);
      chk($sformatf("to_resp.c%0d.wb", k), {31'b0, wb_valid}, 32'd0);
      step();
      data_gnt = 1'b0;
    end
    data_rvalid = 1'b0;

    // Reset while in RESP: request low, back to idle, late rvalid ignored
    present(LW, 32'h400, 32'h0, 5'd9);
    step();
    lsu_valid = 1'b0;
    data_gnt  = 1'b1;
    step();
    data_gnt = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    chk("rst_resp.req", {31'b0, data_req}, 32'd0);
    chk("rst_resp.ready", {31'b0, lsu_ready}, 32'd0);
    step();
    rst         = 1'b0;
    data_rvalid = 1'b1;
    data_rdata  = 32'hFEEDFACE;
    @(negedge clk);
    chk("rst_resp.ready_after", {31'b0, lsu_ready}, 32'd1);
    chk("rst_resp.req_after", {31'b0, data_req}, 32'd0);
    step();
    data_rvalid = 1'b0;
    @(negedge clk);
    chk("rst_resp.no_wb", {31'b0, wb_valid}, 32'd0);
    chk("rst_resp.no_err", {31'b0, bus_err}, 32'd0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
